// File: rtl/layer_serializer_if.sv
// layer_serializer_if: parallel neuron results in, serial word stream and status out
// i_valid/i_data driven by the producing layer (master); x_valid/x_out/busy/overrun driven by the serializer (slave)
interface layer_serializer_if #(
    parameter int NN = 10,
    parameter int dataWidth = 16
);
    logic [NN-1:0]           i_valid;
    logic [NN*dataWidth-1:0] i_data;
    logic                    x_valid;
    logic [dataWidth-1:0]    x_out;
    logic                    busy;
    logic                    overrun;
    modport master (output i_valid, i_data, input x_valid, x_out, busy, overrun);
    modport slave (input i_valid, i_data, output x_valid, x_out, busy, overrun);
endinterface

// File: rtl/layer_serializer.sv
// layer_serializer: double-buffered capture of NN neuron words replayed one per clock, neuron 0 first
// clk, rst (sync active-high); bus.i_valid/i_data: per-neuron strobes and words in
// bus.x_valid/x_out: serial stream out; bus.busy: shifting; bus.overrun: sticky re-strobe error
module layer_serializer #(
    parameter int NN = 10,
    parameter int dataWidth = 16
) (
    input logic clk,
    input logic rst,
    layer_serializer_if.slave bus
);
    localparam int CW = $clog2(NN);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [NN-1:0] mask;
    logic [dataWidth-1:0] cap [NN];
    logic [dataWidth-1:0] shf [NN];
    logic [CW-1:0] cnt, cnt_n;
    logic full, last, xfer, ovr;
    assign full = &mask;
    assign last = cnt == CW'(NN - 1);
    // the shifter accepts a new set when idle or while presenting its final word
    assign xfer = full && (state == IDLE || last);
    always_comb begin
        state_n = xfer ? SHIFT : (state == SHIFT && last) ? IDLE : state;
        cnt_n = xfer ? '0 : (state == SHIFT && !last) ? cnt + 1'b1 : cnt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            mask <= '0;
            ovr <= 1'b0;
            for (int k = 0; k < NN; k++) shf[k] <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            // strobes on a transfer edge land in the freshly cleared mask
            mask <= (xfer ? '0 : mask) | bus.i_valid;
            ovr <= ovr | (!xfer && |(bus.i_valid & mask));
            if (xfer) shf <= cap;
        end
    end
    always_ff @(posedge clk) begin
        for (int k = 0; k < NN; k++)
            if (bus.i_valid[k] && (xfer || !mask[k])) cap[k] <= bus.i_data[k*dataWidth +: dataWidth];
    end
    // idle keeps cnt at the last word, so x_out holds the last presented value
    assign bus.x_out = shf[cnt];
    assign bus.x_valid = state == SHIFT;
    assign bus.busy = state == SHIFT;
    assign bus.overrun = ovr;
endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: table, directed and random checks of layer_serializer against a queue-based model
module tb_layer_serializer;
    localparam int NN = 10;
    localparam int DW = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    layer_serializer_if #(.NN(NN), .dataWidth(DW)) bus ();
    layer_serializer #(.NN(NN), .dataWidth(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_fail = 0;
    logic [DW-1:0] mcap [NN];
    logic [NN-1:0] mmask;
    logic [DW-1:0] q [$];
    logic [DW-1:0] mlast;
    logic mov;
    logic [DW-1:0] seen [$];
    int run, max_run;
    typedef struct {
        logic [NN-1:0] iv;
        logic [DW-1:0] base;
        logic xv;
        logic [DW-1:0] xo;
    } vec_t;
    vec_t tbl [13];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [NN*DW-1:0] mk(input logic [DW-1:0] base);
        logic [NN*DW-1:0] d;
        for (int k = 0; k < NN; k++) d[k*DW +: DW] = base + DW'(k);
        return d;
    endfunction
    // q holds the words still to be presented; q[0] is the one on x_out
    task automatic model_step(input logic r, input logic [NN-1:0] iv, input logic [NN*DW-1:0] d);
        bit xf;
        if (r) begin
            mmask = '0;
            q.delete();
            mlast = '0;
            mov = 1'b0;
            return;
        end
        xf = (&mmask) && q.size() <= 1;
        if (q.size() > 0) void'(q.pop_front());
        if (xf) begin
            for (int k = 0; k < NN; k++) q.push_back(mcap[k]);
            mmask = '0;
        end
        for (int k = 0; k < NN; k++)
            if (iv[k]) begin
                if (!mmask[k]) begin
                    mcap[k] = d[k*DW +: DW];
                    mmask[k] = 1'b1;
                end else mov = 1'b1;
            end
        if (q.size() > 0) mlast = q[0];
    endtask
    task automatic tick(input logic r, input logic [NN-1:0] iv, input logic [NN*DW-1:0] d);
        rst = r;
        bus.i_valid = iv;
        bus.i_data = d;
        @(posedge clk);
        model_step(r, iv, d);
        #1;
        chk("x_valid", 32'(bus.x_valid), 32'(q.size() > 0));
        chk("x_out", 32'(bus.x_out), 32'(mlast));
        chk("busy", 32'(bus.busy), 32'(q.size() > 0));
        chk("overrun", 32'(bus.overrun), 32'(mov));
        if (bus.x_valid) begin
            seen.push_back(bus.x_out);
            run++;
        end else run = 0;
        if (run > max_run) max_run = run;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0);
    endtask
    initial begin
        logic [NN*DW-1:0] d;
        logic [NN-1:0] iv;
        int cnt;
        for (int j = 0; j < 13; j++) begin
            tbl[j].iv = (j == 0) ? '1 : '0;
            tbl[j].base = 16'h0010;
            tbl[j].xv = (j >= 1 && j <= 10);
            tbl[j].xo = (j == 0) ? 16'h0000 : (j <= 10) ? 16'(16'h0010 + j - 1) : 16'h0019;
        end
        mmask = '0;
        mlast = '0;
        mov = 1'b0;
        run = 0;
        max_run = 0;
        bus.i_valid = '0;
        bus.i_data = '0;
        tick(1'b1, '0, '0);
        tick(1'b1, '0, '0);
        // full set in one cycle
        for (int j = 0; j < 13; j++) begin
            tick(1'b0, tbl[j].iv, mk(tbl[j].base));
            chk("tbl_xv", 32'(bus.x_valid), 32'(tbl[j].xv));
            chk("tbl_xout", 32'(bus.x_out), 32'(tbl[j].xo));
            chk("tbl_busy", 32'(bus.busy), 32'(tbl[j].xv));
        end
        chk("tbl_overrun", 32'(bus.overrun), 0);
        // skewed strobes
        seen.delete();
        cnt = 0;
        for (int j = 0; j < 8; j++) begin
            tick(1'b0, j == 0 ? NN'(10'h01F) : j == 7 ? NN'(10'h3E0) : '0, mk(16'h0200));
            cnt += int'(bus.x_valid);
        end
        chk("skew_early_valid", 32'(cnt), 0);
        idle(12);
        chk("skew_count", 32'(seen.size()), 10);
        for (int i = 0; i < NN; i++) chk("skew_word", 32'(seen[i]), 32'(16'h0200 + i));
        // back-to-back sets
        seen.delete();
        max_run = 0;
        for (int j = 0; j < 30; j++)
            tick(1'b0, (j == 0 || j == 4) ? '1 : '0, j == 0 ? mk(16'h0010) : mk(16'h0100));
        chk("b2b_run", 32'(max_run), 20);
        for (int i = 0; i < NN; i++) chk("b2b_word", 32'(seen[10+i]), 32'(16'h0100 + i));
        // overrun on slot 3
        seen.delete();
        for (int j = 0; j < 25; j++) begin
            d = mk(16'h0400);
            iv = '0;
            if (j == 0) begin iv = '1; d = mk(16'h0300); end
            if (j == 2) begin iv = NN'(1) << 3; d[3*DW +: DW] = 16'h0AAA; end
            if (j == 3) begin iv = NN'(1) << 3; d[3*DW +: DW] = 16'h0BBB; end
            if (j == 5) iv = ~(NN'(1) << 3);
            tick(1'b0, iv, d);
            if (j == 2) chk("ovr_before", 32'(bus.overrun), 0);
            if (j == 3) chk("ovr_set", 32'(bus.overrun), 1);
        end
        chk("ovr_sticky", 32'(bus.overrun), 1);
        chk("ovr_word3", 32'(seen[13]), 32'(16'h0AAA));
        tick(1'b1, '0, '0);
        chk("ovr_cleared", 32'(bus.overrun), 0);
        // strobes exactly on transfer edges
        seen.delete();
        max_run = 0;
        for (int j = 0; j < 40; j++)
            tick(1'b0, (j == 0 || j == 1 || j == 11) ? '1 : '0,
                 j == 0 ? mk(16'h0700) : j == 1 ? mk(16'h0800) : mk(16'h0900));
        chk("xedge_run", 32'(max_run), 30);
        chk("xedge_overrun", 32'(bus.overrun), 0);
        chk("xedge_b0", 32'(seen[10]), 32'(16'h0800));
        chk("xedge_c0", 32'(seen[20]), 32'(16'h0900));
        // reset mid-shift
        for (int j = 0; j < 5; j++) tick(1'b0, (j == 0) ? '1 : (j == 2 || j == 3) ? NN'(1) : '0, mk(16'h0500));
        chk("rst_pre_word", 32'(bus.x_out), 32'(16'h0503));
        chk("rst_pre_ovr", 32'(bus.overrun), 1);
        tick(1'b1, '0, '0);
        chk("rst_xv", 32'(bus.x_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ovr", 32'(bus.overrun), 0);
        idle(3);
        chk("rst_quiet", 32'(bus.x_valid), 0);
        seen.delete();
        tick(1'b0, '1, mk(16'h0600));
        idle(14);
        chk("rst_fresh_count", 32'(seen.size()), 10);
        chk("rst_fresh_w0", 32'(seen[0]), 32'(16'h0600));
        // random traffic against the model
        for (int j = 0; j < 400; j++) begin
            for (int k = 0; k < NN; k++) d[k*DW +: DW] = DW'($urandom);
            tick($urandom_range(0, 99) == 0, NN'($urandom & $urandom), d);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/layer_serializer.md
Name: layer_serializer

Overview:
- Inter-layer stage sitting directly downstream of a fully-connected layer.
- Collects the NN parallel neuron results (per-neuron valid strobes, skew tolerated) into a capture buffer.
- Hands them to a shift buffer and replays them one per clock, neuron 0 first, as the serial x_in/x_valid stream for the next layer.
- Double buffering lets the next result set be captured while the current one is still being shifted out.

Parameters:
- NN, 10, number of neurons in the producing layer (>=2).
- dataWidth, 16, width of one neuron output word.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_valid  input  NN  per-neuron output-valid strobes from the producing layer; bit k qualifies word k
- i_data  input  NN*dataWidth  neuron outputs; word k = i_data[k*dataWidth +: dataWidth]
- x_valid  output  1  serial word valid to the next layer
- x_out  output  dataWidth  serial word to the next layer
- busy  output  1  high while the shift buffer is non-empty (state SHIFT)
- overrun  output  1  sticky error flag: a strobe arrived for an already-captured, not-yet-transferred slot

Behaviour:
- Reset: on any rising edge with rst=1, all of the following clear.
  - Outputs x_valid=0, x_out=0, busy=0, overrun=0.
  - Internal state: capture mask=0, shift counter=0, state=IDLE.
  - Reset mid-shift abandons the current set; no further x_valid pulses occur.
- Capture buffer: NN words plus an NN-bit mask.
  - At each edge, for every k with i_valid[k]=1 and mask[k]=0: store word k and set mask[k].
  - If i_valid[k]=1 and mask[k]=1 (and no transfer happens this edge): keep the old word, set overrun.
  - overrun stays set until rst.
  - Capture is full when mask is all ones.
- Transfer: copies all capture words into the shift buffer, clears mask, loads shift counter=0, state=SHIFT. It occurs at an edge where the capture is full and either:
  - state=IDLE, or
  - state=SHIFT with counter=NN-1 (last word currently presented).
- Strobes at a transfer edge:
  - Strobes present on the same edge as a transfer are captured into the freshly cleared mask.
  - They never count as overrun, even for slots that were full.
- State machine:
  - IDLE: x_valid=0, busy=0. Goes to SHIFT on transfer.
  - SHIFT: x_valid=1, busy=1, x_out = shift word[counter]. Counter increments each edge.
  - At counter=NN-1: transfer if the capture is full (counter reloads to 0, no bubble); otherwise go to IDLE.
- Timing and latency:
  - All registered outputs. If the last missing strobe is sampled at edge E, the mask is full after E.
  - Transfer happens at E+1 (if the shifter is free), so the first word is valid after E+1.
  - Exactly NN consecutive x_valid cycles follow, words 0..NN-1 in order.
  - Minimum latency from the final strobe to word 0 is 2 edges.
- x_out holds its last value when x_valid=0; downstream must qualify it with x_valid.
- No backpressure: the next layer must accept one word per cycle while x_valid=1.
- Arithmetic: none. Words pass bit-exact. Counter width is clog2(NN).

Test Plan:
- Reset, then all NN=10 strobes in one cycle with words 0x0010..0x0019 -> 2 edges later, x_valid high for exactly 10 cycles with x_out=0x0010..0x0019 in order; busy matches x_valid; overrun=0.
- Skewed strobes: bits 0-4 at cycle 0, bits 5-9 at cycle 7 -> no x_valid before cycle 9; then 10 words in neuron order.
- Back-to-back: second full set (0x0100..0x0109) completes while first set is shifting -> x_valid stays high 20 consecutive cycles, second set follows with no bubble.
- Overrun: bit 3 strobed twice (0x0AAA then 0x0BBB) before the set completes and while the shifter is busy -> overrun=1 and stays 1; word 3 output is 0x0AAA.
- Strobe on the transfer edge: all bits re-strobed exactly on the transfer edge -> no overrun; new set captured and shifted immediately after the current one.
- rst asserted at the 4th shifted word -> next edge x_valid=0, busy=0, overrun=0; a fresh full set afterwards shifts correctly from word 0.
